if_id_reg: RTL and testbench
============================

Name: if_id_reg

Overview:
- IF/ID pipeline register directly downstream of the fetch stage.
- Captures the fetched instruction with its PC+4 and PC+8, and derives PC.
- Detects instruction-fetch address errors (AdEL) and marks branch-delay-slot instructions for CP0.
- Provides stall-hold and flush-to-bubble for hazard control and exception entry/ERET.

Parameters:
- IM_BASE, 32'h00003000, lowest legal fetch address.
- IM_LAST, 32'h00006FFC, highest legal word-aligned fetch address.
- NOP_WORD, 32'h00000000, instruction word injected on bubble/fault.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- en  in  1  load enable; 0 = stall (hold all state).
- flush  in  1  pipeline flush; loads a bubble (exception entry, ERET).
- jump_ID  in  1  instruction currently in ID is a branch/jump; next captured instruction is its delay slot.
- PC4_IF  in  32  PC+4 from fetch.
- PC8_IF  in  32  PC+8 from fetch.
- Instr_IF  in  32  fetched instruction word.
- Instr_ID  out  32  registered instruction.
- PC_ID  out  32  registered PC (PC4_ID − 4).
- PC4_ID  out  32  registered PC+4.
- PC8_ID  out  32  registered PC+8.
- valid_ID  out  1  1 = real instruction; 0 = bubble.
- BD_ID  out  1  instruction is in a branch-delay slot.
- exc_ID  out  1  fetch exception pending on this instruction.
- ExcCode_ID  out  5  exception code; 5'd4 (AdEL) when exc_ID = 1, else 0.

Behaviour:
- Reset (reset = 0, asynchronous):
  - Instr_ID = NOP_WORD, PC4_ID = IM_BASE+4, PC8_ID = IM_BASE+8.
  - valid_ID = 0, BD_ID = 0, exc_ID = 0, ExcCode_ID = 0.
- Latency: one cycle from IF to ID outputs. PC_ID is combinational from PC4_ID.
- Per rising edge, priority is reset > flush > !en > load:
  - flush = 1: Instr_ID = NOP_WORD, valid_ID = 0, BD_ID = 0, exc_ID = 0, ExcCode_ID = 0. PC4_ID/PC8_ID still load from IF so that CP0 sees a defined PC for the bubble. flush overrides en = 0.
  - en = 0, flush = 0: every register holds.
  - load:
    - PC4_ID, PC8_ID take the IF values.
    - valid_ID = 1.
    - BD_ID = jump_ID sampled on the same edge.
  - Address check on the fetch PC (PC4_IF − 4): fault if PC[1:0] != 0, or PC < IM_BASE, or PC > IM_LAST.
    - Fault: Instr_ID = NOP_WORD, exc_ID = 1, ExcCode_ID = 5'd4.
    - No fault: Instr_ID = Instr_IF, exc_ID = 0, ExcCode_ID = 0.
- Boundary cases:
  - PC = IM_LAST is legal.
  - PC = IM_LAST+4 faults.
  - PC4_IF = 0 gives a wrapped PC of 32'hFFFFFFFC, which faults; subtraction wraps modulo 2^32.
  - jump_ID during a stall is ignored; BD_ID is sampled only on a load.
  - A faulted instruction keeps its BD_ID so that EPC = PC−4 can be formed downstream.
  - A stall held across multiple cycles preserves exc_ID/BD_ID unchanged.

Optional Feature:
- Macro: IF_ID_PERF_EN.
- Defined:
  - Adds outputs stall_cnt[31:0] and bubble_cnt[31:0].
  - stall_cnt increments on each edge with en = 0 and flush = 0.
  - bubble_cnt increments on each edge where flush = 1.
  - Both counters are zeroed by reset and wrap at 2^32.
- Undefined: counters and ports are absent; core behaviour is identical.

Decomposition:
- Shared package holds:
  - ExcCode constants: EXC_INT = 0, EXC_ADEL = 4, EXC_ADES = 5, EXC_RI = 10, EXC_OV = 12.
  - Address constants: IM_BASE, IM_LAST, HANDLER_PC = 32'h00004180.
  - NOP_WORD.
- One natural sub-module: fetch_addr_check.
  - Combinational.
  - Input: PC. Output: fault flag.
  - Reused later by the load/store alignment checks.

Test Plan:
- Reset low mid-run with valid_ID = 1 → outputs go immediately (asynchronously) to Instr = 0, PC4 = 32'h3004, valid = 0, BD = 0, exc = 0.
- Load PC4_IF = 32'h3008, Instr_IF = 32'h24010005, en = 1 → next cycle: Instr_ID = 32'h24010005, PC_ID = 32'h3004, valid = 1, exc = 0.
- en = 0 for 3 cycles with IF inputs changing → ID outputs unchanged. With IF_ID_PERF_EN defined, stall_cnt = 3.
- flush = 1 together with en = 0 → bubble: Instr = 0, valid = 0, BD = 0, and PC4_ID takes PC4_IF.
- jump_ID = 1 on the load of PC4_IF = 32'h3010 → BD_ID = 1. Following load with jump_ID = 0 → BD_ID = 0.
- PC4_IF = 32'h3006 (misaligned), then 32'h7004 (PC = 32'h7000, above IM_LAST), then 32'h7000 (PC = IM_LAST, legal):
  - First two: exc_ID = 1, ExcCode_ID = 4, Instr_ID = 0.
  - Third: exc_ID = 0.

Source files
------------

// File: rtl/if_id_reg_pkg.sv
// Shared constants for the IF/ID stage: exception codes, the instruction-memory window and the bubble word.
// Imported by the IF/ID register, its fetch address checker and the later memory-stage checks.
package if_id_reg_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] IM_BASE    = 32'h0000_3000;
    localparam logic [31:0] IM_LAST    = 32'h0000_6FFC;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg_if.sv
// IF/ID boundary bundle: fetch-side inputs and hazard controls toward the register, decoded-stage view back out.
// master drives fetch/hazard signals; slave is the pipeline register itself.
interface if_id_reg_if;

    logic        en;
    logic        flush;
    logic        jump_ID;
    logic [31:0] PC4_IF;
    logic [31:0] PC8_IF;
    logic [31:0] Instr_IF;

    logic [31:0] Instr_ID;
    logic [31:0] PC_ID;
    logic [31:0] PC4_ID;
    logic [31:0] PC8_ID;
    logic        valid_ID;
    logic        BD_ID;
    logic        exc_ID;
    logic [4:0]  ExcCode_ID;

    modport master (
        output en, flush, jump_ID, PC4_IF, PC8_IF, Instr_IF,
        input  Instr_ID, PC_ID, PC4_ID, PC8_ID, valid_ID, BD_ID, exc_ID, ExcCode_ID
    );

    modport slave (
        input  en, flush, jump_ID, PC4_IF, PC8_IF, Instr_IF,
        output Instr_ID, PC_ID, PC4_ID, PC8_ID, valid_ID, BD_ID, exc_ID, ExcCode_ID
    );

endinterface

// File: rtl/if_id_reg_fetch_addr_check.sv
// Combinational fetch-address legality check: flags misaligned PCs and PCs outside the instruction window.
module if_id_reg_fetch_addr_check
    import if_id_reg_pkg::*;
(
    input  logic [31:0] pc,
    output logic        fault
);

    assign fault = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LAST);

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: one-cycle capture of fetch, AdEL detection, delay-slot marking, stall-hold and flush-to-bubble.
// Optional IF_ID_PERF_EN adds free-running stall and bubble counters.
module if_id_reg
    import if_id_reg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    if_id_reg_if.slave  bus
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    logic [31:0] pc_if;
    logic        fetch_fault;

    // Fetch PC is recovered from PC+4; wraps mod 2^32 so PC4_IF = 0 becomes an illegal 0xFFFFFFFC.
    assign pc_if = bus.PC4_IF - 32'd4;

    if_id_reg_fetch_addr_check u_addr_check (
        .pc    (pc_if),
        .fault (fetch_fault)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.Instr_ID   <= NOP_WORD;
            bus.PC4_ID     <= IM_BASE + 32'd4;
            bus.PC8_ID     <= IM_BASE + 32'd8;
            bus.valid_ID   <= 1'b0;
            bus.BD_ID      <= 1'b0;
            bus.exc_ID     <= 1'b0;
            bus.ExcCode_ID <= EXC_INT;
        end else if (bus.flush) begin
            // Bubble still carries the IF PC so CP0 has a defined address for it.
            bus.Instr_ID   <= NOP_WORD;
            bus.PC4_ID     <= bus.PC4_IF;
            bus.PC8_ID     <= bus.PC8_IF;
            bus.valid_ID   <= 1'b0;
            bus.BD_ID      <= 1'b0;
            bus.exc_ID     <= 1'b0;
            bus.ExcCode_ID <= EXC_INT;
        end else if (bus.en) begin
            bus.PC4_ID     <= bus.PC4_IF;
            bus.PC8_ID     <= bus.PC8_IF;
            bus.valid_ID   <= 1'b1;
            bus.BD_ID      <= bus.jump_ID;
            bus.Instr_ID   <= fetch_fault ? NOP_WORD : bus.Instr_IF;
            bus.exc_ID     <= fetch_fault;
            bus.ExcCode_ID <= fetch_fault ? EXC_ADEL : EXC_INT;
        end
    end

    assign bus.PC_ID = bus.PC4_ID - 32'd4;

`ifdef IF_ID_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt  <= 32'd0;
            bubble_cnt <= 32'd0;
        end else if (bus.flush) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end else if (!bus.en) begin
            stall_cnt  <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Bench for if_id_reg: directed scenarios then random traffic against a behavioural model of the stage.
module tb_if_id_reg;
    localparam logic [31:0] BASE = 32'h0000_3000;
    localparam logic [31:0] LAST = 32'h0000_6FFC;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    if_id_reg_if bus ();

`ifdef IF_ID_PERF_EN
    logic [31:0] stall_cnt, bubble_cnt;
    int unsigned m_stall, m_bubble;
`endif

    if_id_reg dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef IF_ID_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: what the ID stage should be presenting.
    logic [31:0] m_instr, m_pc4, m_pc8;
    logic        m_valid, m_bd, m_exc;
    logic [4:0]  m_code;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit illegal_fetch(input logic [31:0] pc4);
        longint pc;
        pc = (longint'(pc4) + 64'h1_0000_0000 - 4) % 64'h1_0000_0000;
        return (pc % 4 != 0) || (pc < longint'(BASE)) || (pc > longint'(LAST));
    endfunction

    task automatic model_reset();
        m_instr = 32'h0; m_pc4 = BASE + 4; m_pc8 = BASE + 8;
        m_valid = 0; m_bd = 0; m_exc = 0; m_code = 0;
`ifdef IF_ID_PERF_EN
        m_stall = 0; m_bubble = 0;
`endif
    endtask

    task automatic model_edge(input bit en, input bit flush, input bit jump,
                              input logic [31:0] pc4, input logic [31:0] instr);
        if (flush) begin
            m_instr = 0; m_valid = 0; m_bd = 0; m_exc = 0; m_code = 0;
            m_pc4 = pc4; m_pc8 = pc4 + 4;
`ifdef IF_ID_PERF_EN
            m_bubble++;
`endif
        end else if (!en) begin
`ifdef IF_ID_PERF_EN
            m_stall++;
`endif
        end else begin
            m_pc4 = pc4; m_pc8 = pc4 + 4; m_valid = 1; m_bd = jump;
            if (illegal_fetch(pc4)) begin
                m_instr = 0; m_exc = 1; m_code = 5'd4;
            end else begin
                m_instr = instr; m_exc = 0; m_code = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".instr"}, bus.Instr_ID, m_instr);
        chk({tag, ".pc"},    bus.PC_ID, m_pc4 - 4);
        chk({tag, ".pc4"},   bus.PC4_ID, m_pc4);
        chk({tag, ".pc8"},   bus.PC8_ID, m_pc8);
        chk({tag, ".valid"}, 32'(bus.valid_ID), 32'(m_valid));
        chk({tag, ".bd"},    32'(bus.BD_ID), 32'(m_bd));
        chk({tag, ".exc"},   32'(bus.exc_ID), 32'(m_exc));
        chk({tag, ".code"},  32'(bus.ExcCode_ID), 32'(m_code));
`ifdef IF_ID_PERF_EN
        chk({tag, ".stall_cnt"},  stall_cnt, m_stall);
        chk({tag, ".bubble_cnt"}, bubble_cnt, m_bubble);
`endif
    endtask

    task automatic step(input string tag, input bit en, input bit flush, input bit jump,
                        input logic [31:0] pc4, input logic [31:0] instr);
        @(negedge clk);
        bus.en = en; bus.flush = flush; bus.jump_ID = jump;
        bus.PC4_IF = pc4; bus.PC8_IF = pc4 + 4; bus.Instr_IF = instr;
        model_edge(en, flush, jump, pc4, instr);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    function automatic logic [31:0] pick_pc4();
        case ($urandom_range(0, 9))
            0: return 32'h0;
            1: return BASE;
            2: return BASE + 4;
            3: return LAST + 4;
            4: return LAST + 8;
            5: return $urandom();
            6: return (BASE + 4 + ($urandom_range(0, 32'h3FFF) & 32'hFFFF_FFFC)) | 32'($urandom_range(0, 3));
            default: return BASE + 4 + ($urandom_range(0, 32'h3FFF) & 32'hFFFF_FFFC);
        endcase
    endfunction

    initial begin
        reset = 1'b0;
        bus.en = 0; bus.flush = 0; bus.jump_ID = 0;
        bus.PC4_IF = 0; bus.PC8_IF = 0; bus.Instr_IF = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all("reset");

        @(negedge clk) reset = 1'b1;
        step("load_pre", 1, 0, 0, 32'h3040, 32'h1234_5678);
        chk("pre_reset_valid", 32'(bus.valid_ID), 32'd1);

        // Asynchronous reset between clock edges.
        @(negedge clk);
        #2 reset = 1'b0;
        model_reset();
        #1 check_all("async_reset");
        @(negedge clk) reset = 1'b1;

        step("load_3008", 1, 0, 0, 32'h3008, 32'h2401_0005);
        chk("load_pc_const", bus.PC_ID, 32'h3004);
        for (int i = 0; i < 3; i++)
            step("stall", 0, 0, 1, 32'h5000 + 32'(i * 4), $urandom());
`ifdef IF_ID_PERF_EN
        chk("stall_cnt_3", stall_cnt, 32'd3);
`endif
        step("flush_over_stall", 0, 1, 1, 32'h3100, 32'hDEAD_BEEF);
        step("jump_load", 1, 0, 1, 32'h3010, 32'h1111_1111);
        step("bd_slot_next", 1, 0, 0, 32'h3014, 32'h2222_2222);
        step("misaligned", 1, 0, 1, 32'h3006, 32'h3333_3333);
        chk("misaligned_code", 32'(bus.ExcCode_ID), 32'd4);
        step("stall_keeps_exc", 0, 0, 0, 32'h3008, 32'h0);
        step("stall_keeps_exc2", 0, 0, 0, 32'h300C, 32'h0);
        step("above_last", 1, 0, 0, 32'h7004, 32'h4444_4444);
        step("at_last", 1, 0, 0, 32'h7000, 32'h5555_5555);
        chk("at_last_exc", 32'(bus.exc_ID), 32'd0);
        step("below_base", 1, 0, 0, 32'h3000, 32'h6666_6666);
        step("wrap_zero", 1, 0, 0, 32'h0, 32'h7777_7777);
        step("at_base", 1, 0, 0, 32'h3004, 32'h8888_8888);

        for (int i = 0; i < 400; i++) begin
            step("rand",
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 1) == 1,
                 pick_pc4(), $urandom());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running expected done");
        $fatal(1);
    end
endmodule
